// File: rtl/adc_sync_aligner.sv
// Per-channel deskew and sync-framing stage for multi-ADC capture.
// Delays each channel by a programmable number of valid samples and aligns a frame counter to sync.
module adc_sync_aligner #(
    parameter int NUM_ADC   = 4,
    parameter int ADC_BITS  = 8,
    parameter int MAX_DELAY = 8,
    parameter int FRAME_LEN = 1024,
    parameter int DLY_W     = $clog2(MAX_DELAY)
) (
    input  logic                          user_clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [NUM_ADC*ADC_BITS-1:0]   in_data,
    input  logic                          in_sync,
    input  logic [NUM_ADC*DLY_W-1:0]      ch_delay,
    input  logic                          arm,
    output logic                          out_valid,
    output logic [NUM_ADC*ADC_BITS-1:0]   out_data,
    output logic                          out_frame,
    output logic [15:0]                   frame_cnt,
    output logic [1:0]                    state,
    output logic                          sync_err,
    output logic [15:0]                   gap_cnt
);

    localparam int FILL_W = $clog2(MAX_DELAY + 1);
    localparam int CNT_W  = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [ADC_BITS-1:0]         sreg [NUM_ADC][MAX_DELAY-1];
    logic [ADC_BITS-1:0]         win  [NUM_ADC][MAX_DELAY];
    logic [NUM_ADC*ADC_BITS-1:0] tap_data;
    logic [FILL_W-1:0]           fill_q;
    logic                        sync_prev_q;
    logic [CNT_W-1:0]            sample_cnt_q, sample_cnt_d;
    logic [15:0]                 frame_cnt_d, gap_d;
    logic                        sync_err_d, frame_d;
    logic                        sample_fire, sync_edge;

    // A sample is presented only once every tap of the window holds accepted data.
    assign sample_fire = in_valid && (fill_q >= FILL_W'(MAX_DELAY - 1));
    assign sync_edge   = in_valid && in_sync && !sync_prev_q;
    assign state       = state_q;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_ADC; c++)
                for (int k = 0; k < MAX_DELAY - 1; k++)
                    sreg[c][k] <= '0;
        end else if (in_valid) begin
            for (int c = 0; c < NUM_ADC; c++) begin
                sreg[c][0] <= in_data[c*ADC_BITS +: ADC_BITS];
                for (int k = 1; k < MAX_DELAY - 1; k++)
                    sreg[c][k] <= sreg[c][k-1];
            end
        end
    end

    // Tap 0 is the sample arriving this cycle, so delay 0 adds no samples of skew.
    always_comb begin
        tap_data = '0;
        for (int c = 0; c < NUM_ADC; c++) begin
            win[c][0] = in_data[c*ADC_BITS +: ADC_BITS];
            for (int k = 1; k < MAX_DELAY; k++)
                win[c][k] = sreg[c][k-1];
            tap_data[c*ADC_BITS +: ADC_BITS] = win[c][ch_delay[c*DLY_W +: DLY_W]];
        end
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q      <= '0;
            sync_prev_q <= 1'b1;
        end else if (in_valid) begin
            sync_prev_q <= in_sync;
            if (fill_q != FILL_W'(MAX_DELAY))
                fill_q <= fill_q + FILL_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        frame_cnt_d  = frame_cnt;
        sync_err_d   = sync_err;
        gap_d        = gap_cnt;
        frame_d      = 1'b0;
        if (arm) begin
            state_d     = ARMED;
            sync_err_d  = 1'b0;
            gap_d       = '0;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (sync_edge && sample_fire) begin
                        state_d      = RUNNING;
                        frame_d      = 1'b1;
                        sample_cnt_d = CNT_W'(1);
                        frame_cnt_d  = '0;
                    end
                end
                RUNNING: begin
                    if (!in_valid) begin
                        if (gap_cnt != 16'hFFFF)
                            gap_d = gap_cnt + 16'd1;
                    end else if (sync_edge || sample_cnt_q == '0) begin
                        // A sync edge off the frame boundary restarts the frame on this sample.
                        if (sync_edge && sample_cnt_q != '0)
                            sync_err_d = 1'b1;
                        frame_d      = sample_fire;
                        sample_cnt_d = CNT_W'(1);
                        frame_cnt_d  = frame_cnt + 16'd1;
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_frame    <= 1'b0;
            frame_cnt    <= '0;
            sync_err     <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            out_valid    <= sample_fire;
            if (sample_fire)
                out_data <= tap_data;
            out_frame    <= frame_d;
            frame_cnt    <= frame_cnt_d;
            sync_err     <= sync_err_d;
            gap_cnt      <= gap_d;
        end
    end

endmodule

// File: tb/tb_adc_sync_aligner.sv
// Scoreboard bench for adc_sync_aligner: a behavioural model pushes expected outputs per input
// cycle and they are compared one cycle later on the falling clock edge.
module tb_adc_sync_aligner;

    localparam int NUM_ADC   = 4;
    localparam int ADC_BITS  = 8;
    localparam int MAX_DELAY = 8;
    localparam int FRAME_LEN = 1024;
    localparam int DLY_W     = 3;
    localparam int DW        = NUM_ADC * ADC_BITS;

    logic                     user_clk = 1'b0;
    logic                     reset_n  = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_sync  = 1'b0;
    logic                     arm      = 1'b0;
    logic [DW-1:0]            in_data  = '0;
    logic [NUM_ADC*DLY_W-1:0] ch_delay = '0;
    logic                     out_valid;
    logic [DW-1:0]            out_data;
    logic                     out_frame;
    logic [15:0]              frame_cnt;
    logic [1:0]               state;
    logic                     sync_err;
    logic [15:0]              gap_cnt;

    adc_sync_aligner #(
        .NUM_ADC(NUM_ADC), .ADC_BITS(ADC_BITS), .MAX_DELAY(MAX_DELAY),
        .FRAME_LEN(FRAME_LEN), .DLY_W(DLY_W)
    ) dut (
        .user_clk(user_clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_sync(in_sync), .ch_delay(ch_delay), .arm(arm), .out_valid(out_valid),
        .out_data(out_data), .out_frame(out_frame), .frame_cnt(frame_cnt), .state(state),
        .sync_err(sync_err), .gap_cnt(gap_cnt)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          frame;
        logic [15:0]   fcnt;
        logic [1:0]    st;
        logic          err;
        logic [15:0]   gap;
        int            idx;
    } exp_t;

    exp_t        exp_q[$];
    int          frame_idx[$];
    logic [15:0] frame_fc[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [DW-1:0] m_hist[$];
    int            m_fill;
    logic          m_prev;
    logic [1:0]    m_state;
    int            m_cnt;
    logic [15:0]   m_fcnt;
    logic [15:0]   m_gap;
    logic          m_err;
    logic [DW-1:0] m_data;
    int            sample_idx = 0;
    logic [7:0]    ramp = 8'd10;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_hist.delete();
        m_fill  = 0;
        m_prev  = 1'b1;
        m_state = 2'd0;
        m_cnt   = 0;
        m_fcnt  = '0;
        m_gap   = '0;
        m_err   = 1'b0;
        m_data  = '0;
    endtask

    task automatic comparePending();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("out_valid", out_valid, e.valid);
            checkOutput("out_data",  out_data,  e.data);
            checkOutput("out_frame", out_frame, e.frame);
            checkOutput("frame_cnt", frame_cnt, e.fcnt);
            checkOutput("state",     state,     e.st);
            checkOutput("sync_err",  sync_err,  e.err);
            checkOutput("gap_cnt",   gap_cnt,   e.gap);
            if (out_valid && out_frame) begin
                frame_idx.push_back(e.idx);
                frame_fc.push_back(frame_cnt);
            end
        end
    endtask

    // Drives one cycle at the falling edge after checking the previous cycle's outputs.
    task automatic applyStimulus(input logic v, input logic s, input logic a, input bit chk);
        exp_t          e;
        logic          fire, sedge;
        logic [DW-1:0] word;
        int            d;
        @(negedge user_clk);
        comparePending();
        in_valid = v;
        in_sync  = s;
        arm      = a;
        in_data  = {NUM_ADC{ramp}};
        e.idx    = sample_idx;
        if (v) begin
            m_hist.push_front(in_data);
            if (m_hist.size() > MAX_DELAY) void'(m_hist.pop_back());
            if (m_fill < MAX_DELAY) m_fill++;
        end
        fire  = v && (m_fill == MAX_DELAY);
        sedge = v && s && !m_prev;
        if (v) m_prev = s;
        if (fire) begin
            for (int c = 0; c < NUM_ADC; c++) begin
                d    = int'(ch_delay[c*DLY_W +: DLY_W]);
                word = m_hist[d];
                m_data[c*ADC_BITS +: ADC_BITS] = word[c*ADC_BITS +: ADC_BITS];
            end
        end
        e.frame = 1'b0;
        if (a) begin
            m_state = 2'd1;
            m_err   = 1'b0;
            m_gap   = '0;
            m_fcnt  = '0;
        end else if (m_state == 2'd1) begin
            if (sedge && fire) begin
                m_state = 2'd2;
                e.frame = 1'b1;
                m_cnt   = 1;
                m_fcnt  = '0;
            end
        end else if (m_state == 2'd2) begin
            if (!v) begin
                if (m_gap != 16'hFFFF) m_gap = m_gap + 16'd1;
            end else if (sedge || m_cnt == 0) begin
                if (m_cnt != 0) m_err = 1'b1;
                e.frame = 1'b1;
                m_fcnt  = m_fcnt + 16'd1;
                m_cnt   = 1;
            end else begin
                m_cnt = (m_cnt + 1) % FRAME_LEN;
            end
        end
        e.valid = fire;
        e.data  = m_data;
        e.fcnt  = m_fcnt;
        e.st    = m_state;
        e.err   = m_err;
        e.gap   = m_gap;
        if (chk) exp_q.push_back(e);
        if (v) begin
            ramp++;
            sample_idx++;
        end
    endtask

    initial begin
        int          exp_idx[5];
        logic [15:0] exp_fc[5];
        bit          s;
        exp_idx = '{100, 1124, 2148, 2185, 3209};
        exp_fc  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};

        modelReset();
        ch_delay = {3'd3, 3'd2, 3'd1, 3'd0};
        repeat (3) @(negedge user_clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data",  out_data,  '0);
        checkOutput("rst_state",     state,     2'd0);
        checkOutput("rst_gap_cnt",   gap_cnt,   16'd0);
        reset_n = 1'b1;

        // Fill: seven samples (with a hole) keep out_valid low, the eighth raises it.
        for (int i = 0; i < 7; i++) begin
            if (i == 3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_eighth_valid", out_valid, 1'b1);

        // Deskew with in_valid holes.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            if (i % 4 == 1) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Alignment, then a misaligned sync at sample_cnt 37.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        sample_idx = 0;
        for (int i = 0; i <= 3220; i++) begin
            s = (i == 100) || (i == 1124) || (i == 2148) || (i == 2185);
            if (i % 97 == 50) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b1, s, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("frame_count", frame_idx.size(), 5);
        for (int k = 0; k < 5 && k < frame_idx.size(); k++) begin
            checkOutput($sformatf("frame_pos%0d", k), frame_idx[k], exp_idx[k]);
            checkOutput($sformatf("frame_fc%0d", k), frame_fc[k], exp_fc[k]);
        end
        checkOutput("sync_err_set", sync_err, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sync_err_cleared", sync_err, 1'b0);

        // Enter RUNNING, then a long gap to saturate gap_cnt.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("gap_saturated", gap_cnt, 16'hFFFF);
        checkOutput("gap_state_running", state, 2'd2);
        checkOutput("gap_out_valid", out_valid, 1'b0);

        // Reset mid-frame.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_out_valid", out_valid, 1'b0);
        checkOutput("async_out_data",  out_data,  '0);
        checkOutput("async_out_frame", out_frame, 1'b0);
        checkOutput("async_frame_cnt", frame_cnt, 16'd0);
        checkOutput("async_state",     state,     2'd0);
        checkOutput("async_sync_err",  sync_err,  1'b0);
        checkOutput("async_gap_cnt",   gap_cnt,   16'd0);
        exp_q.delete();
        modelReset();
        in_valid = 1'b0;
        repeat (2) @(negedge user_clk);
        reset_n = 1'b1;

        // Sync held high across reset release never forms an edge.
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, (i == 2), 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("held_sync_armed", state, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
